// File: rtl/wbu_regcsr_file.sv
// Writeback/architectural-state block: GPR file, M-mode CSRs, 64-bit counters,
// single-cycle commit with ecall/mret trap entry/return and a one-cycle IFU redirect.
module wbu_regcsr_file #(
  parameter int              XLEN          = 32,
  parameter int              NREG          = 32,
  parameter bit              BYPASS        = 1'b1,
  parameter bit              CAUSE_FROM_A5 = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RST     = 32'h0,
  parameter logic [XLEN-1:0] MSTATUS_RST   = 32'h1800,
  localparam int             AW            = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wbu_receive_valid,
  output logic            wbu_receive_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [11:0]     csr_rs,
  output logic [XLEN-1:0] rsa,
  output logic [XLEN-1:0] rsb,
  output logic [XLEN-1:0] csra,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic            reg_write_en,
  input  logic [11:0]     csr_rd,
  input  logic [XLEN-1:0] csr_wd,
  input  logic            csreg_write_en,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] pc_input,
  input  logic [31:0]     instruction_input,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] commit_pc,
  output logic [31:0]     commit_inst
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic {RUN, REDIRECT} state_t;

  function automatic logic csr_mapped(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: csr_mapped = 1'b1;
      default: csr_mapped = 1'b0;
    endcase
  endfunction

  state_t          state;
  logic [XLEN-1:0] gpr [NREG];
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [63:0]     mcycle;
  logic [63:0]     minstret;
  logic [XLEN-1:0] csr_q;

  logic commit;
  logic is_ecall;
  logic is_mret;
  logic gpr_we;
  logic csr_we;

  assign wbu_receive_ready = (state == RUN);
  assign redirect_valid    = (state == REDIRECT);
  assign commit            = wbu_receive_valid && wbu_receive_ready;
  assign is_ecall          = commit && ecall;
  assign is_mret           = commit && mret && !ecall;
  assign gpr_we            = commit && reg_write_en && (rd != '0);
  assign csr_we            = commit && csreg_write_en;

  always_comb begin
    rsa = (rs1 == '0) ? '0 : gpr[rs1];
    if (BYPASS && gpr_we && (rs1 == rd)) rsa = wd;
  end

  always_comb begin
    rsb = (rs2 == '0) ? '0 : gpr[rs2];
    if (BYPASS && gpr_we && (rs2 == rd)) rsb = wd;
  end

  always_comb begin
    csr_q = '0;
    case (csr_rs)
      CSR_MSTATUS:   csr_q = mstatus;
      CSR_MTVEC:     csr_q = mtvec;
      CSR_MEPC:      csr_q = mepc;
      CSR_MCAUSE:    csr_q = mcause;
      CSR_MCYCLE:    csr_q = mcycle[31:0];
      CSR_MCYCLEH:   csr_q = mcycle[63:32];
      CSR_MINSTRET:  csr_q = minstret[31:0];
      CSR_MINSTRETH: csr_q = minstret[63:32];
      default:       csr_q = '0;
    endcase
    csra = csr_q;
    // Trap commits never forward: their CSR side-effects are overridden by the trap.
    if (BYPASS && csr_we && !ecall && !mret && csr_mapped(csr_rd) && (csr_rs == csr_rd))
      csra = csr_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[rd] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= MSTATUS_RST;
      mtvec    <= MTVEC_RST;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (commit) minstret <= minstret + 64'd1;
      // Explicit counter writes replace the whole-counter increment for this cycle.
      if (csr_we) begin
        case (csr_rd)
          CSR_MSTATUS:   if (!is_ecall && !is_mret) mstatus <= csr_wd;
          CSR_MTVEC:     mtvec <= csr_wd;
          CSR_MEPC:      if (!is_ecall) mepc <= csr_wd;
          CSR_MCAUSE:    if (!is_ecall) mcause <= csr_wd;
          CSR_MCYCLE:    mcycle <= {mcycle[63:32], csr_wd};
          CSR_MCYCLEH:   mcycle <= {csr_wd, mcycle[31:0]};
          CSR_MINSTRET:  minstret <= {minstret[63:32], csr_wd};
          CSR_MINSTRETH: minstret <= {csr_wd, minstret[31:0]};
          default: ;
        endcase
      end
      if (is_ecall) begin
        mepc          <= pc_input;
        mcause        <= CAUSE_FROM_A5 ? gpr[15] : XLEN'(11);
        mstatus[7]    <= mstatus[3];
        mstatus[3]    <= 1'b0;
        mstatus[12:11] <= 2'b11;
      end else if (is_mret) begin
        mstatus[3] <= mstatus[7];
        mstatus[7] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      redirect_pc <= '0;
      commit_pc   <= '0;
      commit_inst <= '0;
    end else begin
      case (state)
        RUN: begin
          if (commit) begin
            commit_pc   <= pc_input;
            commit_inst <= instruction_input;
          end
          if (is_ecall) begin
            redirect_pc <= mtvec;
            state       <= REDIRECT;
          end else if (is_mret) begin
            redirect_pc <= mepc;
            state       <= REDIRECT;
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_regcsr_file.sv
// Directed bench for wbu_regcsr_file: table of commit vectors plus hand-written
// trap, counter-carry and reset-during-redirect sequences.
module tb_wbu_regcsr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbu_receive_valid;
  logic        wbu_receive_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] csr_rs, csr_rd;
  logic [31:0] rsa, rsb, csra, wd, csr_wd, pc_input, instruction_input;
  logic        reg_write_en, csreg_write_en, ecall, mret;
  logic        redirect_valid;
  logic [31:0] redirect_pc, commit_pc, commit_inst;

  int checks = 0;
  int failures = 0;

  always #50 clk = ~clk;

  wbu_regcsr_file dut (
    .clk(clk), .rst(rst),
    .wbu_receive_valid(wbu_receive_valid), .wbu_receive_ready(wbu_receive_ready),
    .rs1(rs1), .rs2(rs2), .csr_rs(csr_rs),
    .rsa(rsa), .rsb(rsb), .csra(csra),
    .rd(rd), .wd(wd), .reg_write_en(reg_write_en),
    .csr_rd(csr_rd), .csr_wd(csr_wd), .csreg_write_en(csreg_write_en),
    .ecall(ecall), .mret(mret),
    .pc_input(pc_input), .instruction_input(instruction_input),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_pc(commit_pc), .commit_inst(commit_inst)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        we;
    logic [11:0] crd;
    logic [31:0] cwd;
    logic        cwe;
    logic [4:0]  rs;
    logic [11:0] crs;
    logic [31:0] exp_byp;
    logic [31:0] exp_rsa;
    logic [31:0] exp_cbyp;
    logic [31:0] exp_csra;
  } vec_t;

  vec_t v [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_rs = a;
    #1;
    chk(name, csra, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wbu_receive_valid = 1'b0;
    reg_write_en      = 1'b0;
    csreg_write_en    = 1'b0;
    ecall             = 1'b0;
    mret              = 1'b0;
  endtask

  initial begin
    v[0] = '{5'd5,  32'hDEADBEEF, 1'b1, 12'h000, 32'h0,        1'b0, 5'd5,  12'hB02,
             32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h1};
    v[1] = '{5'd0,  32'h1234,     1'b1, 12'h000, 32'h0,        1'b0, 5'd0,  12'hB02,
             32'h0, 32'h0, 32'h1, 32'h2};
    v[2] = '{5'd15, 32'hB,        1'b1, 12'h305, 32'h80000100, 1'b1, 5'd15, 12'h305,
             32'hB, 32'hB, 32'h80000100, 32'h80000100};
    v[3] = '{5'd6,  32'h11,       1'b0, 12'h7C0, 32'h55,       1'b1, 5'd6,  12'h7C0,
             32'h0, 32'h0, 32'h0, 32'h0};
    v[4] = '{5'd7,  32'hA5A5,     1'b1, 12'h341, 32'h1234,     1'b1, 5'd5,  12'h341,
             32'hDEADBEEF, 32'hDEADBEEF, 32'h1234, 32'h1234};
    v[5] = '{5'd7,  32'h0,        1'b0, 12'h342, 32'h7,        1'b1, 5'd7,  12'h342,
             32'hA5A5, 32'hA5A5, 32'h7, 32'h7};
    v[6] = '{5'd0,  32'h0,        1'b0, 12'h300, 32'h1808,     1'b1, 5'd15, 12'h300,
             32'hB, 32'hB, 32'h1808, 32'h1808};

    rst = 1'b1;
    idle();
    rs1 = '0; rs2 = '0; rd = '0; wd = '0;
    csr_rs = '0; csr_rd = '0; csr_wd = '0;
    pc_input = '0; instruction_input = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", {31'b0, wbu_receive_ready}, 32'h1);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_commit_pc", commit_pc, 32'h0);
    chk("rst_commit_inst", commit_inst, 32'h0);
    rs1 = 5'd5;
    chk_csr("rst_mstatus", 12'h300, 32'h1800);
    chk_csr("rst_mtvec", 12'h305, 32'h0);
    chk_csr("rst_mcycle", 12'hB00, 32'h0);
    chk_csr("rst_minstret", 12'hB02, 32'h0);
    chk("rst_gpr5", rsa, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wbu_receive_valid = 1'b1;
      rd = v[i].rd; wd = v[i].wd; reg_write_en = v[i].we;
      csr_rd = v[i].crd; csr_wd = v[i].cwd; csreg_write_en = v[i].cwe;
      rs1 = v[i].rs; rs2 = v[i].rs; csr_rs = v[i].crs;
      pc_input = 32'h100 + 32'(i) * 32'd4;
      instruction_input = 32'h13 + 32'(i);
      #1;
      chk($sformatf("v%0d_rsa_byp", i), rsa, v[i].exp_byp);
      chk($sformatf("v%0d_rsb_byp", i), rsb, v[i].exp_byp);
      chk($sformatf("v%0d_csra_byp", i), csra, v[i].exp_cbyp);
      tick();
      idle();
      #1;
      chk($sformatf("v%0d_rsa", i), rsa, v[i].exp_rsa);
      chk($sformatf("v%0d_csra", i), csra, v[i].exp_csra);
      chk($sformatf("v%0d_commit_pc", i), commit_pc, 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("v%0d_commit_inst", i), commit_inst, 32'h13 + 32'(i));
    end
    chk_csr("minstret_7", 12'hB02, 32'd7);
    chk_csr("minstreth_0", 12'hB82, 32'd0);

    // ecall with a conflicting mepc write; valid held through REDIRECT
    wbu_receive_valid = 1'b1; ecall = 1'b1;
    pc_input = 32'h80000010; instruction_input = 32'h00000073;
    csr_rd = 12'h341; csr_wd = 32'hFFFF; csreg_write_en = 1'b1;
    csr_rs = 12'h341;
    #1;
    chk("ecall_no_csr_byp", csra, 32'h1234);
    tick();
    chk("ecall_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("ecall_ready_low", {31'b0, wbu_receive_ready}, 32'h0);
    chk("ecall_redirect_pc", redirect_pc, 32'h80000100);
    chk("ecall_commit_pc", commit_pc, 32'h80000010);
    chk("ecall_commit_inst", commit_inst, 32'h00000073);
    chk_csr("ecall_mepc", 12'h341, 32'h80000010);
    chk_csr("ecall_mcause", 12'h342, 32'hB);
    chk_csr("ecall_mstatus", 12'h300, 32'h1880);
    chk_csr("ecall_minstret", 12'hB02, 32'd8);
    tick();
    chk("post_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("post_redirect_ready", {31'b0, wbu_receive_ready}, 32'h1);
    chk_csr("held_valid_minstret", 12'hB02, 32'd8);
    chk_csr("held_valid_mepc", 12'h341, 32'h80000010);
    idle();

    // mret returns to the trapping pc and restores MIE
    wbu_receive_valid = 1'b1; mret = 1'b1;
    pc_input = 32'h80000020; instruction_input = 32'h30200073;
    tick();
    idle();
    chk("mret_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("mret_redirect_pc", redirect_pc, 32'h80000010);
    chk("mret_commit_pc", commit_pc, 32'h80000020);
    chk_csr("mret_mstatus", 12'h300, 32'h1888);
    chk_csr("mret_minstret", 12'hB02, 32'd9);
    tick();
    chk("mret_done_valid", {31'b0, redirect_valid}, 32'h0);
    chk("mret_done_ready", {31'b0, wbu_receive_ready}, 32'h1);

    // mcycle low-word write then high-word write, then carry on next increment
    wbu_receive_valid = 1'b1; csreg_write_en = 1'b1;
    csr_rd = 12'hB00; csr_wd = 32'hFFFFFFFF;
    tick();
    csr_rd = 12'hB80; csr_wd = 32'h0;
    tick();
    idle();
    chk_csr("mcycle_lo_hold", 12'hB00, 32'hFFFFFFFF);
    chk_csr("mcycleh_written", 12'hB80, 32'h0);
    tick();
    chk_csr("mcycle_lo_wrap", 12'hB00, 32'h0);
    chk_csr("mcycleh_carry", 12'hB80, 32'h1);
    chk_csr("minstret_11", 12'hB02, 32'd11);

    // reset asserted while in REDIRECT
    wbu_receive_valid = 1'b1; ecall = 1'b1; pc_input = 32'h80000040;
    tick();
    idle();
    chk("rr_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs1 = 5'd5; rs2 = 5'd15;
    chk("rr_redirect_valid_low", {31'b0, redirect_valid}, 32'h0);
    chk("rr_ready", {31'b0, wbu_receive_ready}, 32'h1);
    chk("rr_redirect_pc", redirect_pc, 32'h0);
    chk("rr_commit_pc", commit_pc, 32'h0);
    chk_csr("rr_mtvec", 12'h305, 32'h0);
    chk_csr("rr_mstatus", 12'h300, 32'h1800);
    chk_csr("rr_mepc", 12'h341, 32'h0);
    chk_csr("rr_minstret", 12'hB02, 32'h0);
    chk("rr_gpr5", rsa, 32'h0);
    chk("rr_gpr15", rsb, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbu_regcsr_file.md
Name: wbu_regcsr_file

Overview:
Parametrised writeback/architectural-state block for the NPC core. It holds the GPR file (RV32I or RV32E depth), a decoded M-mode CSR file with 12-bit CSR addresses, and the 64-bit mcycle/minstret counters. It commits one instruction per valid/ready handshake and handles ecall/mret trap entry and return. After each trap it enters a one-cycle redirect state that steers the IFU.

Parameters:
XLEN, 32, datapath width.
NREG, 32, number of GPRs; 32 or 16 (RV32E); AW = $clog2(NREG).
BYPASS, 1, 1 = read ports return the committing write data in the same cycle; 0 = return stored value only.
CAUSE_FROM_A5, 1, 1 = ecall loads mcause from x15; 0 = constant 11.
MTVEC_RST, 32'h0, reset value of mtvec.
MSTATUS_RST, 32'h1800, reset value of mstatus.

Ports:
clk  in  1  clock
rst  in  1  reset
wbu_receive_valid  in  1  upstream commit request
wbu_receive_ready  out  1  block can accept a commit
rs1  in  AW  GPR read address A
rs2  in  AW  GPR read address B
csr_rs  in  12  CSR read address
rsa  out  XLEN  GPR[rs1]
rsb  out  XLEN  GPR[rs2]
csra  out  XLEN  CSR[csr_rs]
rd  in  AW  GPR write address
wd  in  XLEN  GPR write data
reg_write_en  in  1  GPR write enable
csr_rd  in  12  CSR write address
csr_wd  in  XLEN  CSR write data
csreg_write_en  in  1  CSR write enable
ecall  in  1  commit is ecall
mret  in  1  commit is mret
pc_input  in  XLEN  PC of committing instruction
instruction_input  in  32  committing instruction word
redirect_valid  out  1  one-cycle trap/return redirect
redirect_pc  out  XLEN  redirect target
commit_pc  out  XLEN  PC of last committed instruction
commit_inst  out  32  last committed instruction word

Behaviour:
- Single clock clk; reset rst synchronous, active-high. All state changes occur on posedge clk.
- Reset values: all GPRs 0; mepc 0; mcause 0; mtvec MTVEC_RST; mstatus MSTATUS_RST; mcycle 0; minstret 0; commit_pc 0; commit_inst 0; redirect_valid 0; redirect_pc 0; state RUN, so wbu_receive_ready = 1.
- Reset mid-operation, including during REDIRECT, returns all state to reset values on the next edge.
- Commit = wbu_receive_valid && wbu_receive_ready. All side-effects occur only on a commit edge.
- Each commit:
  - minstret += 1; commit_pc <= pc_input; commit_inst <= instruction_input.
  - If reg_write_en and rd != 0, GPR[rd] <= wd.
- x0 reads 0 always; writes to x0 are dropped.
- CSR map: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82. Any other address reads 0, and writes to it are ignored.
- mcycle increments every non-reset cycle. An explicit CSR write to mcycle or mcycleh replaces the increment in that cycle. The same rule applies to minstret/minstreth versus the commit increment.
- ecall commit:
  - mepc <= pc_input.
  - mcause <= (CAUSE_FROM_A5 ? GPR[15] : 11).
  - mstatus.MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
  - redirect_pc <= mtvec.
  - ecall takes priority over a same-cycle CSR write to mepc, mcause or mstatus.
- mret commit:
  - mstatus.MIE <= MPIE; MPIE <= 1.
  - redirect_pc <= mepc, using the pre-update value.
- ecall and mret asserted together: ecall wins; mret is ignored.
- FSM states are RUN and REDIRECT.
  - RUN: ready = 1. An ecall or mret commit moves to REDIRECT.
  - REDIRECT: lasts exactly 1 cycle; redirect_valid = 1, ready = 0; then returns to RUN. redirect_valid is low in RUN.
- Read latency 0 (combinational) for rsa, rsb and csra.
- BYPASS=1: when a commit writes GPR[rd] and rs1 (or rs2) == rd != 0, rsa (or rsb) = wd. The same bypass applies to csra for a non-trap CSR write with csr_rs == csr_rd.
- BYPASS=0: reads return stored values only.
- mcycle/minstret wrap modulo 2^64.
- NREG=16: rd/rs are 4 bits; GPR[15] is still a5.

Test Plan:
- Reset, then NREG=32, commit rd=5 wd=0xDEADBEEF, reg_write_en=1 -> after edge rsa (rs1=5) = 0xDEADBEEF, minstret=1; BYPASS=1 shows 0xDEADBEEF combinationally in the commit cycle.
- Commit rd=0 wd=0x1234 -> rsa (rs1=0) stays 0.
- mtvec written 0x80000100; x15=0xB; ecall at pc 0x80000010 -> mepc=0x80000010, mcause=0xB; next cycle redirect_valid=1, redirect_pc=0x80000100, ready=0; the cycle after, ready=1 and redirect_valid=0.
- Valid held high during REDIRECT -> no commit and minstret unchanged.
- mret after that ecall -> redirect_pc=0x80000010 and mstatus.MIE restored from MPIE.
- CSR write 0xB00=0xFFFFFFFF, then 0xB80=0 -> two cycles later mcycleh=1 (carry).
- Unmapped 0x7C0 write 0x55 -> reads 0.
- rst asserted during REDIRECT -> next cycle redirect_valid=0, ready=1, all GPRs 0.
